instruction_memory_loadable: RTL and testbench
==============================================

Name: instruction_memory_loadable

Overview:
Parametrised, synchronous-read instruction memory for the RISC-V core, replacing the fixed combinational ROM image. Program words are loaded at run time through a write port while the block is in LOAD mode. Fetches are served in RUN mode with a one-cycle req/valid handshake. Misaligned and out-of-range fetches are flagged and return a NOP instead of undefined data.

Parameters:
Width, 32, instruction/data word width in bits
Depth, 1024, number of words (power of 2, >= 2)
AddrWidth, 32, byte-address width of fetch_addr and prog_addr
NopInstr, 32'h00000013, word returned on faulted fetch (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
prog_start  input  1  pulse: enter LOAD mode, clear load bookkeeping
prog_we  input  1  write prog_data at prog_addr (LOAD mode only)
prog_addr  input  AddrWidth  byte address of word to write
prog_data  input  Width  word to write
prog_done  input  1  pulse: leave LOAD, enter RUN
fetch_req  input  1  fetch request (RUN mode only)
fetch_addr  input  AddrWidth  byte address of instruction (PC)
fetch_valid  output  1  response valid, one cycle after accepted fetch_req
instruction  output  Width  fetched word (held between responses)
fetch_misaligned  output  1  fault: fetch_addr[1:0] != 0, valid with fetch_valid
fetch_oob  output  1  fault: word index >= Depth, valid with fetch_valid
mode_run  output  1  1 = RUN, 0 = LOAD
prog_count  output  clog2(Depth)+1  accepted program writes since last prog_start
prog_err  output  1  sticky: a rejected program write occurred since prog_start

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low: rst_n=0 immediately forces the reset values.
- Reset values: state=LOAD, mode_run=0, fetch_valid=0, instruction=NopInstr, fetch_misaligned=0, fetch_oob=0, prog_count=0, prog_err=0. Memory contents are not reset.
- Word index: fetch_addr >> 2 (likewise prog_addr >> 2). Bits [1:0] must be 0. Index >= Depth is out of range, including any set upper bits beyond clog2(Depth)+2.
- FSM has two states, LOAD and RUN.
- LOAD -> RUN on prog_done. RUN -> LOAD on prog_start.
- prog_start in LOAD stays in LOAD, clears prog_count and prog_err.
- prog_start and prog_done in the same cycle: prog_start wins (LOAD, counters cleared).
- LOAD writes: on a clk edge with prog_we=1 and an aligned, in-range address, mem[index] <= prog_data and prog_count increments.
  - prog_count saturates at Depth.
  - Rewriting the same address still counts.
- prog_we together with prog_done in the same cycle: the write is performed and counted, then the state is RUN.
- Rejected writes set prog_err=1 and do not touch memory. A write is rejected if it is misaligned, out of range, or issued in RUN.
  - prog_we together with prog_start in RUN: prog_start takes effect that cycle, the write is rejected, and prog_err is set after the clear.
- RUN fetch: fetch_req=1 at edge N gives fetch_valid=1 during cycle N+1 with instruction=mem[index]. Latency is exactly 1.
  - Back-to-back requests produce back-to-back valids (throughput 1/cycle).
  - fetch_req=0 gives fetch_valid=0 next cycle. instruction, fetch_misaligned and fetch_oob hold their last values.
- Fetch faults: instruction=NopInstr and the matching flag is set; both flags may be 1 together. Memory is not read.
- fetch_req in LOAD is ignored: fetch_valid=0 next cycle, outputs held.
- A fetch issued in the prog_start cycle is ignored. A fetch issued in the prog_done cycle is ignored, because the state is still LOAD at that edge.
- Reset mid-load or mid-fetch: pending response dropped (fetch_valid=0), state LOAD, memory keeps previously written words.
- Reading a never-written word returns X in simulation. This is not checked by the bench.

Test Plan:
1. Reset, then prog_we at addr 0,4,8 with 32'h05F00263, 32'h01DE8D33, 32'h01DD0D33, then prog_done -> prog_count=3, prog_err=0, mode_run=1 next cycle.
2. RUN, fetch_req on 3 consecutive cycles with addr 0,4,8 -> fetch_valid=1 on the following 3 cycles with instruction 05F00263, 01DE8D33, 01DD0D33, no faults.
3. Fetch addr 6 -> fetch_misaligned=1, instruction=00000013. Fetch addr 4096 (Depth=1024) -> fetch_oob=1, instruction=00000013. Fetch addr 4098 -> both flags=1.
4. In RUN, prog_we addr 0 data FFFFFFFF -> prog_err=1, and a later fetch at addr 0 still returns 05F00263. In LOAD, prog_we addr 4097 -> prog_err=1 and prog_count unchanged.
5. prog_start and prog_done in the same cycle -> mode_run=0, prog_count=0. A fetch_req in that cycle -> no fetch_valid.
6. Assert rst_n=0 mid-stream while fetch_valid=1 -> fetch_valid drops immediately (asynchronous). After release plus prog_done, fetch at addr 4 returns 01DE8D33 (memory retained).

Source files
------------

// File: rtl/instruction_memory_loadable_if.sv
// instruction_memory_loadable_if: program-load and fetch bus of the loadable instruction memory
interface instruction_memory_loadable_if #(
  parameter int Width     = 32,
  parameter int Depth     = 1024,
  parameter int AddrWidth = 32
);
  localparam int CW = $clog2(Depth) + 1;
  logic                 prog_start;
  logic                 prog_we;
  logic [AddrWidth-1:0] prog_addr;
  logic [Width-1:0]     prog_data;
  logic                 prog_done;
  logic                 fetch_req;
  logic [AddrWidth-1:0] fetch_addr;
  logic                 fetch_valid;
  logic [Width-1:0]     instruction;
  logic                 fetch_misaligned;
  logic                 fetch_oob;
  logic                 mode_run;
  logic [CW-1:0]        prog_count;
  logic                 prog_err;
  modport master (
    output prog_start, prog_we, prog_addr, prog_data, prog_done, fetch_req, fetch_addr,
    input  fetch_valid, instruction, fetch_misaligned, fetch_oob, mode_run, prog_count, prog_err
  );
  modport slave (
    input  prog_start, prog_we, prog_addr, prog_data, prog_done, fetch_req, fetch_addr,
    output fetch_valid, instruction, fetch_misaligned, fetch_oob, mode_run, prog_count, prog_err
  );
endinterface

// File: rtl/instruction_memory_loadable.sv
// instruction_memory_loadable: run-time loadable instruction memory with 1-cycle fetch and fault flags
module instruction_memory_loadable #(
  parameter int              Width     = 32,
  parameter int              Depth     = 1024,
  parameter int              AddrWidth = 32,
  parameter logic [Width-1:0] NopInstr = 32'h00000013
) (
  input logic clk,
  input logic rst_n,
  instruction_memory_loadable_if.slave bus
);
  localparam int IW = $clog2(Depth);
  localparam int CW = IW + 1;
  typedef enum logic {LOAD, RUN} state_t;
  state_t state, nxt;
  logic [Width-1:0] mem [Depth];
  logic [IW-1:0] p_idx, f_idx;
  logic p_ok, wr, rd, f_mis, f_oob;
  logic [CW-1:0] cnt_inc, cnt_nxt;
  // Any set bit above the word index makes an address out of range.
  always_comb begin
    p_idx   = bus.prog_addr[IW+1:2];
    f_idx   = bus.fetch_addr[IW+1:2];
    p_ok    = bus.prog_addr[1:0] == 2'b00 && !(|bus.prog_addr[AddrWidth-1:IW+2]);
    f_mis   = |bus.fetch_addr[1:0];
    f_oob   = |bus.fetch_addr[AddrWidth-1:IW+2];
    wr      = bus.prog_we && p_ok && state == LOAD;
    rd      = bus.fetch_req && state == RUN && !bus.prog_start;
    nxt     = bus.prog_start ? LOAD : bus.prog_done ? RUN : state;
    cnt_inc = bus.prog_count == CW'(Depth) ? bus.prog_count : bus.prog_count + 1'b1;
    cnt_nxt = bus.prog_start ? (wr ? CW'(1) : '0) : wr ? cnt_inc : bus.prog_count;
  end
  always_ff @(posedge clk)
    if (wr) mem[p_idx] <= bus.prog_data;
  // prog_start clears the error first, so a write rejected in that cycle still latches it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state                <= LOAD;
      bus.mode_run         <= 1'b0;
      bus.fetch_valid      <= 1'b0;
      bus.instruction      <= NopInstr;
      bus.fetch_misaligned <= 1'b0;
      bus.fetch_oob        <= 1'b0;
      bus.prog_count       <= '0;
      bus.prog_err         <= 1'b0;
    end else begin
      state           <= nxt;
      bus.mode_run    <= nxt == RUN;
      bus.fetch_valid <= rd;
      bus.prog_count  <= cnt_nxt;
      bus.prog_err    <= (bus.prog_err && !bus.prog_start) || (bus.prog_we && !wr);
      if (rd) begin
        bus.fetch_misaligned <= f_mis;
        bus.fetch_oob        <= f_oob;
        bus.instruction      <= (f_mis || f_oob) ? NopInstr : mem[f_idx];
      end
    end
endmodule

// File: tb/tb_instruction_memory_loadable.sv
// tb_instruction_memory_loadable: randomized bench against a word-array reference model plus directed literal checks
module tb_instruction_memory_loadable;
  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  instruction_memory_loadable_if #(.Width(32), .Depth(DEPTH), .AddrWidth(32)) bus ();
  instruction_memory_loadable #(.Width(32), .Depth(DEPTH), .AddrWidth(32), .NopInstr(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  logic [31:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  bit          e_run, e_valid, e_mis, e_oob, e_err, e_known;
  logic [31:0] e_instr;
  int          e_cnt;
  logic w_ok, f_ok, f_bad;
  assign w_ok  = !e_run && bus.prog_we && bus.prog_addr % 4 == 0 && bus.prog_addr / 4 < DEPTH;
  assign f_ok  = e_run && bus.fetch_req && !bus.prog_start;
  assign f_bad = bus.fetch_addr % 4 != 0 || bus.fetch_addr / 4 >= DEPTH;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e_run <= 0; e_valid <= 0; e_instr <= NOP; e_mis <= 0; e_oob <= 0;
      e_cnt <= 0; e_err <= 0; e_known <= 1;
    end else begin
      if (w_ok) begin
        m_mem[bus.prog_addr / 4] <= bus.prog_data;
        m_wr[bus.prog_addr / 4]  <= 1;
      end
      e_cnt   <= bus.prog_start ? int'(w_ok) : (w_ok && e_cnt < DEPTH) ? e_cnt + 1 : e_cnt;
      e_err   <= (e_err && !bus.prog_start) || (bus.prog_we && !w_ok);
      e_run   <= bus.prog_start ? 0 : bus.prog_done ? 1 : e_run;
      e_valid <= f_ok;
      if (f_ok) begin
        e_mis   <= bus.fetch_addr % 4 != 0;
        e_oob   <= bus.fetch_addr / 4 >= DEPTH;
        e_instr <= f_bad ? NOP : m_mem[(bus.fetch_addr / 4) % DEPTH];
        e_known <= f_bad || m_wr[(bus.fetch_addr / 4) % DEPTH];
      end
    end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("mode_run", 64'(bus.mode_run), 64'(e_run));
    chk("fetch_valid", 64'(bus.fetch_valid), 64'(e_valid));
    chk("fetch_misaligned", 64'(bus.fetch_misaligned), 64'(e_mis));
    chk("fetch_oob", 64'(bus.fetch_oob), 64'(e_oob));
    chk("prog_count", 64'(bus.prog_count), 64'(e_cnt));
    chk("prog_err", 64'(bus.prog_err), 64'(e_err));
    if (e_known) chk("instruction", 64'(bus.instruction), 64'(e_instr));
  end
  task automatic drive(input bit ps, input bit pw, input logic [31:0] pa, input logic [31:0] pd,
                       input bit dn, input bit fr, input logic [31:0] fa);
    bus.prog_start = ps; bus.prog_we = pw; bus.prog_addr = pa; bus.prog_data = pd;
    bus.prog_done = dn; bus.fetch_req = fr; bus.fetch_addr = fa;
    @(posedge clk);
    #2;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask
  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 15);
    return r == 0 ? 32'(4096 + 4 * $urandom_range(0, 15)) :
           r == 1 ? 32'($urandom) :
           r == 2 ? 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3)) :
                    32'(4 * $urandom_range(0, 63));
  endfunction
  initial begin
    bus.prog_start = 0; bus.prog_we = 0; bus.prog_addr = 0; bus.prog_data = 0;
    bus.prog_done = 0; bus.fetch_req = 0; bus.fetch_addr = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset instruction", 64'(bus.instruction), 64'(NOP));
    chk("reset prog_count", 64'(bus.prog_count), 64'd0);
    rst_n = 1;
    drive(0, 1, 0, 32'h05F00263, 0, 0, 0);
    drive(0, 1, 4, 32'h01DE8D33, 0, 0, 0);
    drive(0, 1, 8, 32'h01DD0D33, 1, 0, 0);
    chk("load count 3", 64'(bus.prog_count), 64'd3);
    chk("load err 0", 64'(bus.prog_err), 64'd0);
    chk("load mode_run", 64'(bus.mode_run), 64'd1);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("fetch0 valid", 64'(bus.fetch_valid), 64'd1);
    chk("fetch0 data", 64'(bus.instruction), 64'h05F00263);
    drive(0, 0, 0, 0, 0, 1, 4);
    chk("fetch4 data", 64'(bus.instruction), 64'h01DE8D33);
    drive(0, 0, 0, 0, 0, 1, 8);
    chk("fetch8 data", 64'(bus.instruction), 64'h01DD0D33);
    chk("fetch8 flags", 64'({bus.fetch_misaligned, bus.fetch_oob}), 64'd0);
    drive(0, 0, 0, 0, 0, 1, 6);
    chk("misaligned flag", 64'({bus.fetch_misaligned, bus.fetch_oob}), 64'b10);
    chk("misaligned nop", 64'(bus.instruction), 64'(NOP));
    drive(0, 0, 0, 0, 0, 1, 4096);
    chk("oob flag", 64'({bus.fetch_misaligned, bus.fetch_oob}), 64'b01);
    drive(0, 0, 0, 0, 0, 1, 4098);
    chk("both flags", 64'({bus.fetch_misaligned, bus.fetch_oob}), 64'b11);
    chk("both nop", 64'(bus.instruction), 64'(NOP));
    idle();
    chk("idle valid", 64'(bus.fetch_valid), 64'd0);
    chk("held flags", 64'({bus.fetch_misaligned, bus.fetch_oob}), 64'b11);
    drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
    chk("run write err", 64'(bus.prog_err), 64'd1);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("run write ignored", 64'(bus.instruction), 64'h05F00263);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("start clears err", 64'(bus.prog_err), 64'd0);
    drive(0, 1, 4097, 32'h12345678, 0, 0, 0);
    chk("bad write err", 64'(bus.prog_err), 64'd1);
    chk("bad write count", 64'(bus.prog_count), 64'd0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 1, 0);
    chk("start+done mode", 64'(bus.mode_run), 64'd0);
    chk("start+done count", 64'(bus.prog_count), 64'd0);
    chk("start+done no valid", 64'(bus.fetch_valid), 64'd0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 4);
    chk("pre-reset valid", 64'(bus.fetch_valid), 64'd1);
    #1 rst_n = 0;
    #1 chk("async reset valid", 64'(bus.fetch_valid), 64'd0);
    chk("async reset mode", 64'(bus.mode_run), 64'd0);
    @(posedge clk);
    #2 rst_n = 1;
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 4);
    chk("retained data", 64'(bus.instruction), 64'h01DE8D33);
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 3; i++) drive(0, 1, 32'(4 * (i % DEPTH)), $urandom, 0, 0, 0);
    chk("saturated count", 64'(bus.prog_count), 64'(DEPTH));
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      bit ps = $urandom_range(0, 39) == 0;
      bit pw = $urandom_range(0, 2) == 0;
      if (ps && !e_run) pw = 0;
      drive(ps, pw, rand_addr(), $urandom, $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1, rand_addr());
    end
    idle();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
